// File: rtl/seq_divider_ctrl.sv
// Multicycle unsigned restoring divider controller.
// One quotient bit per cycle, using an external combinational subtractor
// (sub_s = sub_a - sub_b) that is shared with the ALU datapath.
module seq_divider_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_c0,
  input  logic [WIDTH-1:0] sub_s
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_ash;
  logic             w_rtop;
  logic             w_borrow;
  logic             w_fits;
  logic [WIDTH-1:0] w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // A new request is only taken while not iterating.
  assign w_accept = start && (r_state != S_RUN);
  assign w_zero   = (divisor == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Shifted partial remainder; its bit shifted out (rtop) is the 33rd bit,
  // which guarantees a fit without being stored.
  assign w_ash  = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_rtop = r_r[WIDTH-1];

  // Borrow of the 32-bit subtraction, recovered from operand and result MSBs
  // since the subtractor's carry output is not routed back.
  assign w_borrow = (~w_ash[WIDTH-1] & r_d[WIDTH-1]) |
                    (~(w_ash[WIDTH-1] ^ r_d[WIDTH-1]) & sub_s[WIDTH-1]);
  assign w_fits   = w_rtop | ~w_borrow;
  assign w_r_nxt  = w_fits ? sub_s : w_ash;
  assign w_q_nxt  = {r_q[WIDTH-2:0], w_fits};

  assign sub_c0      = 1'b0;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and Moore outputs; subtractor operands only driven in RUN.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    sub_a  = '0;
    sub_b  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        sub_a = w_ash;
        sub_b = r_d;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = w_zero ? S_DONE : S_RUN;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Working registers: load operands on accept, one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_d <= divisor;
      r_q <= dividend;
      r_r <= '0;
    end else if (r_state == S_RUN) begin
      r_r <= w_r_nxt;
      r_q <= w_q_nxt;
    end
  end

  // Iteration counter and visible results; results move only at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_dbz <= w_zero;
      if (w_zero) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quotient  <= w_q_nxt;
        r_remainder <= w_r_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed testbench for seq_divider_ctrl with a behavioural subtractor.
module tb_seq_divider_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero, sub_c0;
  logic [31:0] quotient, remainder, sub_a, sub_b, sub_s;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder),
    .sub_a(sub_a), .sub_b(sub_b), .sub_c0(sub_c0), .sub_s(sub_s)
  );

  // External structural subtractor stand-in.
  assign sub_s = sub_a - sub_b;

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Negedges waited until done is seen (0 if already high); -1 on timeout.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1) begin
      if (cycles >= budget) begin cycles = -1; return; end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quot got %h want 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_rem got %h want 0", remainder); end
    n_checks++; if (sub_a !== 32'd0 || sub_b !== 32'd0) begin n_fail++; $display("FAIL reset_sub got %h/%h want 0/0", sub_a, sub_b); end
    n_checks++; if (sub_c0 !== 1'b0) begin n_fail++; $display("FAIL reset_c0 got %b want 0", sub_c0); end
  endtask

  task automatic test_basic();
    int cyc;
    start_op(32'd100, 32'd7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    n_checks++; if (sub_b !== 32'd7) begin n_fail++; $display("FAIL basic_subb got %h want 7", sub_b); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got %b want 0", done); end
    wait_done(40, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL basic_latency got %0d want 32", cyc); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_quot got %0d want 14", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_rem got %0d want 2", remainder); end
    n_checks++; if (busy !== 1'b0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_flags got busy=%b dbz=%b want 0/0", busy, div_by_zero); end
    n_checks++; if (sub_a !== 32'd0 || sub_b !== 32'd0) begin n_fail++; $display("FAIL basic_sub_idle got %h/%h want 0/0", sub_a, sub_b); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got %b want 0", done); end
    n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_fail++; $display("FAIL basic_hold got %0d r %0d want 14 r 2", quotient, remainder); end
  endtask

  task automatic test_boundaries();
    int cyc;
    start_op(32'hFFFFFFFF, 32'd1);
    wait_done(40, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL bnd1_latency got %0d want 32", cyc); end
    n_checks++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'd0) begin n_fail++; $display("FAIL bnd1_result got %h r %h want ffffffff r 0", quotient, remainder); end
    start_op(32'hFFFFFFFF, 32'h80000000);
    wait_done(40, cyc);
    n_checks++; if (quotient !== 32'd1 || remainder !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL bnd2_result got %h r %h want 1 r 7fffffff", quotient, remainder); end
    start_op(32'h80000000, 32'h80000001);
    wait_done(40, cyc);
    n_checks++; if (quotient !== 32'd0 || remainder !== 32'h80000000) begin n_fail++; $display("FAIL bnd3_result got %h r %h want 0 r 80000000", quotient, remainder); end
  endtask

  task automatic test_div_zero();
    int cyc;
    start_op(32'd5, 32'd0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dbz_done got %b want 1", done); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    n_checks++; if (quotient !== 32'hFFFFFFFF || remainder !== 32'd5) begin n_fail++; $display("FAIL dbz_result got %h r %h want ffffffff r 5", quotient, remainder); end
    n_checks++; if (busy !== 1'b0 || sub_a !== 32'd0 || sub_b !== 32'd0) begin n_fail++; $display("FAIL dbz_idle got busy=%b sub=%h/%h want 0", busy, sub_a, sub_b); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold got done=%b dbz=%b want 0/1", done, div_by_zero); end
    start_op(32'd9, 32'd3);
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
    n_checks++; if (quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_quot_hold got %h want ffffffff", quotient); end
    wait_done(40, cyc);
    n_checks++; if (quotient !== 32'd3 || remainder !== 32'd0) begin n_fail++; $display("FAIL dbz_next got %0d r %0d want 3 r 0", quotient, remainder); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int seen;
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl got busy=%b done=%b want 0/0", busy, done); end
    n_checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin n_fail++; $display("FAIL abort_result got %h r %h want 0 r 0", quotient, remainder); end
    n_checks++; if (sub_a !== 32'd0 || sub_b !== 32'd0) begin n_fail++; $display("FAIL abort_sub got %h/%h want 0/0", sub_a, sub_b); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    start_op(32'd1000, 32'd3);
    wait_done(40, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL abort_latency got %0d want 32", cyc); end
    n_checks++; if (quotient !== 32'd333 || remainder !== 32'd1) begin n_fail++; $display("FAIL abort_rerun got %0d r %0d want 333 r 1", quotient, remainder); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    start_op(32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (sub_b !== 32'd3) begin n_fail++; $display("FAIL ign_subb got %h want 3", sub_b); end
    wait_done(40, cyc);
    n_checks++; if (cyc !== 27) begin n_fail++; $display("FAIL ign_latency got %0d want 27", cyc); end
    n_checks++; if (quotient !== 32'd333 || remainder !== 32'd1) begin n_fail++; $display("FAIL ign_result got %0d r %0d want 333 r 1", quotient, remainder); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    dividend = 32'd77; divisor = 32'd10;
    wait_done(40, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 32", cyc); end
    n_checks++; if (quotient !== 32'd10 || remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_first got %0d r %0d want 10 r 0", quotient, remainder); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got busy=%b done=%b want 1/0", busy, done); end
    wait_done(40, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL b2b_gap got %0d want 32 (+1)", cyc); end
    n_checks++; if (quotient !== 32'd7 || remainder !== 32'd7) begin n_fail++; $display("FAIL b2b_second got %0d r %0d want 7 r 7", quotient, remainder); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got done=%b busy=%b want 0/0", done, busy); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_basic();
    test_boundaries();
    test_div_zero();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
